// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier controller.
// Holds the FSM state encoding and default WIDTH / APPROX_BITS values.
package mult_pkg;

    localparam int MULT_WIDTH  = 8;
    localparam int MULT_APPROX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/acc_adder.sv
// Accumulate adder: WIDTH-bit operands, WIDTH+1-bit sum.
// Ports: i_a, i_b (operands), o_sum (carry + sum).
// Build macro APPROX_MULT_EN selects a lower-part-OR adder: the low
// APPROX_BITS bits are a|b, the upper bits add exactly with no carry-in.
module acc_adder
    import mult_pkg::*;
#(
    parameter int WIDTH       = MULT_WIDTH,
    parameter int APPROX_BITS = MULT_APPROX
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

`ifdef APPROX_MULT_EN
    localparam int HI_W = WIDTH - APPROX_BITS;

    logic [HI_W:0]        w_hi;
    logic [APPROX_BITS-1:0] w_lo;

    assign w_lo  = i_a[APPROX_BITS-1:0] | i_b[APPROX_BITS-1:0];
    assign w_hi  = {1'b0, i_a[WIDTH-1:APPROX_BITS]}
                 + {1'b0, i_b[WIDTH-1:APPROX_BITS]};
    assign o_sum = {w_hi, w_lo};
`else
    assign o_sum = {1'b0, i_a} + {1'b0, i_b};
`endif

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add unsigned multiplier, fixed WIDTH-cycle RUN phase.
// Ports: clk, rst_n (sync, active-low), start/op_a/op_b in,
// ready/busy/done/product out. Macro APPROX_MULT_EN: approximate adder.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH       = MULT_WIDTH,
    parameter int APPROX_BITS = MULT_APPROX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_low;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sum;

    acc_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_add (
        .i_a   (r_acc_hi),
        .i_b   (r_mcand),
        .o_sum (w_add)
    );

    // {carry,acc_hi}; the carry only lives for one cycle since the
    // right shift always moves it into acc_hi's MSB.
    assign w_sum = r_low[0] ? w_add : {1'b0, r_acc_hi};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_low     <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_low    <= op_b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_low    <= {w_sum[0], r_low[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        // Shifted {acc_hi,low} of this final step.
                        r_product <= {w_sum, r_low[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl at WIDTH=8.
// Build with +define+APPROX_MULT_EN to check the approximate adder.
module tb_shift_add_mult_ctrl;

    localparam int W = 8;
    localparam int A = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    shift_add_mult_ctrl #(
        .WIDTH       (W),
        .APPROX_BITS (A)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: true product, or the lower-part-OR variant where each
    // partial-product accumulation approximates its low A bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
`ifdef APPROX_MULT_EN
        logic [2*W:0] acc;
        logic [W:0]   s;
        logic [W-1:0] hi;
        acc = {1'b0, W'(0), b};
        for (int i = 0; i < W; i++) begin
            hi = acc[2*W-1:W];
            if (acc[0]) begin
                s[A-1:0] = hi[A-1:0] | a[A-1:0];
                s[W:A] = (W-A+1)'(hi[W-1:A]) + (W-A+1)'(a[W-1:A]);
            end else begin
                s = {1'b0, hi};
            end
            acc = {s, acc[W-1:0]} >> 1;
        end
        return acc[2*W-1:0];
`else
        return (2*W)'(a) * (2*W)'(b);
`endif
    endfunction

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    // One full operation: start pulse, bounded wait for done, checks
    // latency, result, and ready returning on the following cycle.
    task automatic run_op(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int k;
        int n;
        wait_ready(nm);
        start = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clk);
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({nm, "_done_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, cyc - k, W);
            chk({nm, "_product"}, product, exp);
            chk({nm, "_busy_in_done"}, busy, 1);
            @(negedge clk);
            chk({nm, "_ready_after"}, ready, 1);
            chk({nm, "_done_1cyc"}, done, 0);
            chk({nm, "_hold"}, product, exp);
        end
    endtask

    initial begin
        int d0;
        int t[3];
        logic [2*W-1:0] p[3];
        int n;

`ifdef APPROX_MULT_EN
        vecs.push_back('{8'd15, 8'd15, 16'd127});
        vecs.push_back('{8'd0, 8'd200, 16'd0});
        vecs.push_back('{8'd200, 8'd0, 16'd0});
`else
        vecs.push_back('{8'd13, 8'd11, 16'h008F});
        vecs.push_back('{8'd255, 8'd255, 16'hFE01});
        vecs.push_back('{8'd0, 8'd200, 16'd0});
        vecs.push_back('{8'd15, 8'd15, 16'h00E1});
        vecs.push_back('{8'd1, 8'd1, 16'd1});
        vecs.push_back('{8'd128, 8'd2, 16'd256});
        vecs.push_back('{8'd200, 8'd0, 16'd0});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].exp);

        // Random against reference model
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb));
        end

        // start re-pulsed during RUN and DONE must be ignored
        wait_ready("ign");
        d0 = done_cnt;
        start = 1'b1;
        op_a = 8'd13;
        op_b = 8'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        op_a = 8'd99;
        op_b = 8'd77;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_ready_after", ready, 1);
        repeat (12) @(negedge clk);
        chk("ign_product", product, ref_mul(8'd13, 8'd11));
        chk("ign_done_count", done_cnt - d0, 1);
        chk("ign_idle", ready, 1);

        // Reset on the 4th RUN cycle, start asserted alongside reset
        d0 = done_cnt;
        start = 1'b1;
        op_a = 8'd50;
        op_b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_still_idle", ready, 1);
        run_op("post_rst", 8'd9, 8'd7, ref_mul(8'd9, 8'd7));

        // start held high: back-to-back operations
        wait_ready("b2b");
        start = 1'b1;
        op_a = 8'd2;
        op_b = 8'd3;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!done && n < 30) begin
                @(negedge clk);
                n++;
            end
            t[i] = cyc;
            p[i] = product;
            if (!done) chk($sformatf("b2b_timeout%0d", i), 0, 1);
            op_a = W'(4 + 2 * i);
            op_b = W'(5 + 2 * i);
            if (i == 2) start = 1'b0;
            @(negedge clk);
        end
        chk("b2b_p0", p[0], ref_mul(8'd2, 8'd3));
        chk("b2b_p1", p[1], ref_mul(8'd4, 8'd5));
        chk("b2b_p2", p[2], ref_mul(8'd6, 8'd7));
        chk("b2b_gap01", t[1] - t[0], W + 2);
        chk("b2b_gap12", t[2] - t[1], W + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
